// File: rtl/wb_queue.sv
// Write-back queue: FIFO of {rd, data, mode} between execute/memory and the regfile write port.
// Optional forwarding port enabled by defining WB_BYPASS_EN.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_ADDR_LEN
`define REG_ADDR_LEN 5
`endif

module wb_queue #(
  parameter int DEPTH = 4  // power of 2, 2..16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [`REG_ADDR_LEN-1:0] alu_rd,
  input  logic [`WIDTH-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [`REG_ADDR_LEN-1:0] mem_rd,
  input  logic [`WIDTH-1:0]        mem_data,
  input  logic [1:0]               mem_mode,
  input  logic                     wb_hold,
  output logic [`REG_ADDR_LEN-1:0] rc,
  output logic [`WIDTH-1:0]        dataC,
  output logic                     w_en,
  output logic [1:0]               w_mode,
  output logic [4:0]               count,
  output logic                     full,
  output logic                     empty
`ifdef WB_BYPASS_EN
  ,
  input  logic [`REG_ADDR_LEN-1:0] byp_addr,
  output logic                     byp_hit,
  output logic [`WIDTH-1:0]        byp_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [`REG_ADDR_LEN-1:0] entry_rd   [DEPTH];
  logic [`WIDTH-1:0]        entry_data [DEPTH];
  logic [1:0]               entry_mode [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [4:0]       count_reg;

  logic                     mem_xfer;
  logic                     alu_xfer;
  logic                     push;
  logic                     pop;
  logic [`REG_ADDR_LEN-1:0] push_rd;
  logic [`WIDTH-1:0]        push_data;
  logic [1:0]               push_mode;

  assign count = count_reg;
  assign full  = (count_reg == 5'(DEPTH));
  assign empty = (count_reg == 5'd0);

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign mem_xfer = mem_valid && mem_ready;
  assign alu_xfer = alu_valid && alu_ready;

  always_comb begin
    push_rd   = alu_rd;
    push_data = alu_data;
    push_mode = 2'd0;
    if (mem_xfer) begin
      push_rd   = mem_rd;
      push_data = mem_data;
      push_mode = (mem_mode == 2'd3) ? 2'd0 : mem_mode;
    end
  end

  // Writes to r0 are accepted from the source but dropped here.
  assign push = (mem_xfer || alu_xfer) && (push_rd != '0);
  assign pop  = !empty && !wb_hold;

  always_ff @(posedge clk) begin
    if (push) begin
      entry_rd[wr_ptr_reg]   <= push_rd;
      entry_data[wr_ptr_reg] <= push_data;
      entry_mode[wr_ptr_reg] <= push_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 5'd1;
      else if (pop && !push)
        count_reg <= count_reg - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en   <= 1'b0;
      rc     <= '0;
      dataC  <= '0;
      w_mode <= 2'd0;
    end else begin
      w_en <= pop;
      if (pop) begin
        rc     <= entry_rd[rd_ptr_reg];
        dataC  <= entry_data[rd_ptr_reg];
        w_mode <= entry_mode[rd_ptr_reg];
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the last match (youngest) wins; the output
  // register is only consulted when no queued entry matches.
  always_comb begin
    logic [PTR_W-1:0] idx;
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PTR_W'(k);
      if ((5'(k) < count_reg) && (entry_rd[idx] == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = entry_data[idx];
      end
    end
    if (!byp_hit && w_en && (rc == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = dataC;
    end
    if (byp_addr == '0) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4); bypass checks run when WB_BYPASS_EN is defined.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic [1:0]  mem_mode = '0;
  logic        wb_hold = 1'b0;
  logic [4:0]  rc;
  logic [31:0] dataC;
  logic        w_en;
  logic [1:0]  w_mode;
  logic [4:0]  count;
  logic        full;
  logic        empty;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_addr = '0;
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  int checks = 0;
  int errors = 0;

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_mode(mem_mode), .wb_hold(wb_hold),
    .rc(rc), .dataC(dataC), .w_en(w_en), .w_mode(w_mode),
    .count(count), .full(full), .empty(empty)
`ifdef WB_BYPASS_EN
    , .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Async reset asserted before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_w_en", 32'(w_en), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    mem_valid = 1'b1;
    #1;
    check("rst_alu_ready_memv", 32'(alu_ready), 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single ALU push.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    check("alu1_count", 32'(count), 32'd1);
    tick();
    check("alu1_w_en", 32'(w_en), 32'd1);
    check("alu1_rc", 32'(rc), 32'd3);
    check("alu1_data", dataC, 32'hDEADBEEF);
    check("alu1_mode", 32'(w_mode), 32'd0);
    check("alu1_empty", 32'(empty), 32'd1);
    tick();
    check("alu1_w_en_off", 32'(w_en), 32'd0);
    check("alu1_rc_hold", 32'(rc), 32'd3);

    // Simultaneous mem and alu: mem first.
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h11; mem_mode = 2'd2;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h22;
    #1;
    check("both_alu_ready", 32'(alu_ready), 32'd0);
    check("both_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    #1;
    check("both_alu_ready2", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("both_w1_en", 32'(w_en), 32'd1);
    check("both_w1_rc", 32'(rc), 32'd5);
    check("both_w1_data", dataC, 32'h11);
    check("both_w1_mode", 32'(w_mode), 32'd2);
    tick();
    check("both_w2_rc", 32'(rc), 32'd6);
    check("both_w2_data", dataC, 32'h22);
    check("both_w2_mode", 32'(w_mode), 32'd0);
    tick();
    check("both_idle", 32'(w_en), 32'd0);

    // Fill with hold, then drain in order.
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(100 + i);
      tick();
      check($sformatf("fill%0d_w_en", i), 32'(w_en), 32'd0);
      check($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
    end
    alu_valid = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_mem_ready", 32'(mem_ready), 32'd0);
    check("fill_alu_ready", 32'(alu_ready), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h99; mem_mode = 2'd0;
    tick();
    mem_valid = 1'b0;
    check("fill_reject_count", 32'(count), 32'd4);
    wb_hold = 1'b0;
    #1;
    check("fill_pop_ready", 32'(mem_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain%0d_w_en", i), 32'(w_en), 32'd1);
      check($sformatf("drain%0d_rc", i), 32'(rc), 32'(10 + i));
      check($sformatf("drain%0d_data", i), dataC, 32'(100 + i));
      check($sformatf("drain%0d_count", i), 32'(count), 32'(3 - i));
    end
    tick();
    check("drain_done", 32'(w_en), 32'd0);

    // rd=0 dropped; mode 3 mapped to 0.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    tick();
    alu_valid = 1'b0;
    check("r0_count", 32'(count), 32'd0);
    tick();
    check("r0_no_write", 32'(w_en), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77; mem_mode = 2'd3;
    tick();
    mem_valid = 1'b0;
    check("m3_count", 32'(count), 32'd1);
    tick();
    check("m3_w_en", 32'(w_en), 32'd1);
    check("m3_rc", 32'(rc), 32'd7);
    check("m3_mode", 32'(w_mode), 32'd0);
    check("m3_data", dataC, 32'h77);

    // Reset with entries in flight.
    wb_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(12 + i); alu_data = 32'(200 + i);
      tick();
    end
    alu_valid = 1'b0;
    check("inflight_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_w_en", 32'(w_en), 32'd0);
    check("arst_rc", 32'(rc), 32'd0);
    check("arst_data", dataC, 32'd0);
    check("arst_mode", 32'(w_mode), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    wb_hold = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst%0d_w_en", i), 32'(w_en), 32'd0);
      check($sformatf("post_rst%0d_count", i), 32'(count), 32'd0);
    end

`ifdef WB_BYPASS_EN
    wb_hold = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA;
    tick();
    alu_data = 32'hB;
    tick();
    alu_valid = 1'b0;
    byp_addr = 5'd9;
    #1;
    check("byp_hit", 32'(byp_hit), 32'd1);
    check("byp_young", byp_data, 32'hB);
    byp_addr = 5'd0;
    #1;
    check("byp_r0_hit", 32'(byp_hit), 32'd0);
    check("byp_r0_data", byp_data, 32'd0);
    byp_addr = 5'd4;
    #1;
    check("byp_miss", 32'(byp_hit), 32'd0);
    byp_addr = 5'd9;
    wb_hold = 1'b0;
    tick();
    check("byp_q_after_pop", byp_data, 32'hB);
    tick();
    check("byp_outreg_hit", 32'(byp_hit), 32'd1);
    check("byp_outreg_data", byp_data, 32'hB);
    tick();
    check("byp_gone", 32'(byp_hit), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
